// File: rtl/exme_latch.sv
// -----------------------------------------------------------------------------
// exme_latch
//
// EX/MEM pipeline register and memory-access sequencer. Captures the execute
// stage result, holds it stable while a multi-cycle memory access is in flight,
// stalls upstream during the hold and counts the stall cycles.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a MEM_WAIT that lasts TIMEOUT_CYC cycles without done is forced
//               to complete, the op's reg-write is dropped and mem_err sticks.
//   undefined : MEM_WAIT waits for done indefinitely, mem_err is tied low.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ex_*                execute-stage instruction fields
//   flush               kill the op currently offered by EX
//   done                memory stage finished the current access (pulse)
//   ExMe_out_*          registered instruction toward the memory stage
//   stall               upstream must hold (combinational)
//   mem_stall_cnt       saturating count of stall cycles
//   mem_err             sticky timeout flag
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | register holds a bubble or a non-memory op
// ST_MEM_WAIT | register holds a valid memory op awaiting done
// -----------------------------------------------------------------------------
module exme_latch #(
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_out,
    input  logic [DATA_W-1:0]  ex_reg_2,
    input  logic               ex_mem_wrt,
    input  logic               ex_mem_en,
    input  logic               ex_reg_wrt,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               flush,
    input  logic               done,
    output logic [DATA_W-1:0]  ExMe_out_alu_out,
    output logic [DATA_W-1:0]  ExMe_out_reg_2,
    output logic               ExMe_out_mem_wrt,
    output logic               ExMe_out_mem_en,
    output logic               ExMe_out_reg_wrt,
    output logic [RADDR_W-1:0] ExMe_out_rd,
    output logic               ExMe_out_valid,
    output logic               stall,
    output logic [31:0]        mem_stall_cnt,
    output logic               mem_err
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               w_stall;
    logic               w_load;
    logic               w_kill;
    logic               w_timeout;

    logic [DATA_W-1:0]  r_alu_out;
    logic [DATA_W-1:0]  r_reg_2;
    logic               r_mem_wrt;
    logic               r_mem_en;
    logic               r_reg_wrt;
    logic [RADDR_W-1:0] r_rd;
    logic               r_valid;
    logic [31:0]        r_stall_cnt;

    // The wait counter must be able to hold TIMEOUT_CYC-1.
    if (TIMEOUT_CYC < 2) begin : g_param_check
        $error("exme_latch: TIMEOUT_CYC must be at least 2");
    end

    // -------------------------------------------------------------------------
    // Optional forced completion of a memory access that never sees done
    // -------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_mem_err;

    assign w_timeout = (r_state == ST_MEM_WAIT) && !done &&
                       (r_wait_cnt == WCNT_W'(TIMEOUT_CYC - 1));

    // Cleared on every load, so it only advances while an access is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_load) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else if (w_timeout) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: stall / load decision and next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_stall     = 1'b0;
        w_load      = 1'b1;
        w_kill      = !ex_valid || flush;
        w_state_nxt = r_state;

        // A timeout cycle behaves exactly like a done cycle.
        if (r_state == ST_MEM_WAIT && !done && !w_timeout) begin
            w_stall = 1'b1;
        end
        w_load = !w_stall;

        if (w_load) begin
            if (!w_kill && ex_mem_en) begin
                w_state_nxt = ST_MEM_WAIT;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline register. Flush only ever kills the incoming op; a held access
    // is untouched because w_load is low while it waits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= '0;
            r_reg_2   <= '0;
            r_mem_wrt <= 1'b0;
            r_mem_en  <= 1'b0;
            r_reg_wrt <= 1'b0;
            r_rd      <= '0;
            r_valid   <= 1'b0;
        end else if (w_load) begin
            r_alu_out <= ex_alu_out;
            r_reg_2   <= ex_reg_2;
            r_rd      <= ex_rd;
            r_valid   <= !w_kill;
            r_mem_wrt <= ex_mem_wrt && !w_kill;
            r_mem_en  <= ex_mem_en  && !w_kill;
            r_reg_wrt <= ex_reg_wrt && !w_kill;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ExMe_out_alu_out = r_alu_out;
    assign ExMe_out_reg_2   = r_reg_2;
    assign ExMe_out_mem_wrt = r_mem_wrt;
    assign ExMe_out_mem_en  = r_mem_en;
    // A timed-out op must not commit its register write downstream.
    assign ExMe_out_reg_wrt = r_reg_wrt && !w_timeout;
    assign ExMe_out_rd      = r_rd;
    assign ExMe_out_valid   = r_valid;
    assign stall            = w_stall;
    assign mem_stall_cnt    = r_stall_cnt;

endmodule
